// File: rtl/ascon_io_pkg.sv
// Shared types and sizing helpers for the Ascon stream shell.
package ascon_io_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLoaded,
    StRun,
    StUnload
  } shell_state_e;

  localparam logic ModeEnc = 1'b0;
  localparam logic ModeDec = 1'b1;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lane_shift_reg.sv
// MSB-first lane shift register with parallel capture; exposes its top TAPW bits.
module lane_shift_reg #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DW    = 8,
  parameter int unsigned TAPW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic [DW-1:0]    lane_in,
  output logic [TAPW-1:0]  tap
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // Parallel capture wins over a shift in the same cycle.
  always_comb begin
    sr_d = sr_q;
    if (load_en) begin
      sr_d = load_val;
    end else if (shift_en) begin
      sr_d = (sr_q << DW) | WIDTH'(lane_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign tap = sr_q[WIDTH-1 -: TAPW];

endmodule

// File: rtl/ascon_stream_shell.sv
// Lane-wide load/launch/unload shell around an Ascon core with valid/ready handshakes.
module ascon_stream_shell
  import ascon_io_pkg::*;
#(
  parameter int unsigned K  = 128,
  parameter int unsigned L  = 40,
  parameter int unsigned Y  = 96,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] key_lane,
  input  logic [DW-1:0] nonce_lane,
  input  logic [DW-1:0] ad_lane,
  input  logic [DW-1:0] data_lane,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic [K-1:0]  core_key,
  output logic [127:0]  core_nonce,
  output logic [L-1:0]  core_ad,
  output logic [Y-1:0]  core_data,
  output logic          core_enc_start,
  output logic          core_dec_start,
  input  logic          core_ready,
  input  logic [Y-1:0]  core_result,
  input  logic [127:0]  core_tag,
  input  logic          core_auth,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [DW-1:0] out_tag,
  output logic          out_last,
  output logic          auth_ok
);

  localparam int unsigned NIN  = ceil_div(max3((K > 128) ? K : 128, L, Y), DW);
  localparam int unsigned NOUT = ceil_div((Y > 128) ? Y : 128, DW);
  localparam int unsigned FW   = NIN * DW;
  localparam int unsigned OW   = NOUT * DW;
  localparam int unsigned CW   = $clog2(NIN) + 1;

  shell_state_e  state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          auth_ok_q, auth_ok_d;
  logic          enc_pulse_q, enc_pulse_d;
  logic          dec_pulse_q, dec_pulse_d;
  logic          core_ready_q;
  logic          capture;
  logic          in_fire;
  logic          out_fire;

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    mode_d      = mode_q;
    busy_d      = busy_q;
    auth_ok_d   = auth_ok_q;
    enc_pulse_d = 1'b0;
    dec_pulse_d = 1'b0;
    capture     = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    unique case (state_q)
      StIdle, StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_cnt_q == CW'(NIN - 1)) begin
            in_cnt_d = '0;
            state_d  = StLoaded;
          end else begin
            in_cnt_d = in_cnt_q + CW'(1);
            state_d  = StLoad;
          end
        end
      end
      StLoaded: begin
        if (start) begin
          mode_d      = mode;
          busy_d      = 1'b1;
          auth_ok_d   = 1'b0;
          enc_pulse_d = (mode == ModeEnc);
          dec_pulse_d = (mode == ModeDec);
          state_d     = StRun;
        end
      end
      StRun: begin
        // Only a fresh rising edge counts; a level left high from a prior run is ignored.
        if (core_ready && !core_ready_q) begin
          capture   = 1'b1;
          auth_ok_d = (mode_q == ModeDec) && core_auth;
          out_cnt_d = '0;
          state_d   = StUnload;
        end
      end
      StUnload: begin
        out_valid = 1'b1;
        out_last  = (out_cnt_q == CW'(NOUT - 1));
        if (out_ready) begin
          if (out_last) begin
            out_cnt_d = '0;
            busy_d    = 1'b0;
            state_d   = StIdle;
          end else begin
            out_cnt_d = out_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      auth_ok_q    <= 1'b0;
      enc_pulse_q  <= 1'b0;
      dec_pulse_q  <= 1'b0;
      core_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      auth_ok_q    <= auth_ok_d;
      enc_pulse_q  <= enc_pulse_d;
      dec_pulse_q  <= dec_pulse_d;
      core_ready_q <= core_ready;
    end
  end

  assign busy           = busy_q;
  assign auth_ok        = auth_ok_q;
  assign core_enc_start = enc_pulse_q;
  assign core_dec_start = dec_pulse_q;

  lane_shift_reg #(.WIDTH(FW), .DW(DW), .TAPW(K)) u_key_sr (
    .clk      (clk),
    .rst      (rst),
    .load_en  (1'b0),
    .load_val ('0),
    .shift_en (in_fire),
    .lane_in  (key_lane),
    .tap      (core_key)
  );

  lane_shift_reg #(.WIDTH(FW), .DW(DW), .TAPW(128)) u_nonce_sr (
    .clk      (clk),
    .rst      (rst),
    .load_en  (1'b0),
    .load_val ('0),
    .shift_en (in_fire),
    .lane_in  (nonce_lane),
    .tap      (core_nonce)
  );

  lane_shift_reg #(.WIDTH(FW), .DW(DW), .TAPW(L)) u_ad_sr (
    .clk      (clk),
    .rst      (rst),
    .load_en  (1'b0),
    .load_val ('0),
    .shift_en (in_fire),
    .lane_in  (ad_lane),
    .tap      (core_ad)
  );

  lane_shift_reg #(.WIDTH(FW), .DW(DW), .TAPW(Y)) u_data_sr (
    .clk      (clk),
    .rst      (rst),
    .load_en  (1'b0),
    .load_val ('0),
    .shift_en (in_fire),
    .lane_in  (data_lane),
    .tap      (core_data)
  );

  // Results are left-aligned so the first beat carries the MSBs; the tail is zero fill.
  lane_shift_reg #(.WIDTH(OW), .DW(DW), .TAPW(DW)) u_res_sr (
    .clk      (clk),
    .rst      (rst),
    .load_en  (capture),
    .load_val (OW'(core_result) << (OW - Y)),
    .shift_en (out_fire),
    .lane_in  ('0),
    .tap      (out_data)
  );

  lane_shift_reg #(.WIDTH(OW), .DW(DW), .TAPW(DW)) u_tag_sr (
    .clk      (clk),
    .rst      (rst),
    .load_en  (capture),
    .load_val (OW'(core_tag) << (OW - 128)),
    .shift_en (out_fire),
    .lane_in  ('0),
    .tap      (out_tag)
  );

endmodule
